// File: rtl/channel_selector.sv
// channel_selector: bus-and-tag channel sequencer for one I/O request; define CHANNEL_PARITY_CHECK_EN to check bus_in odd parity
module channel_selector #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  dev_address,
  input  logic [7:0]  dev_command,
  input  logic [15:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic [2:0]  result,
  output logic [7:0]  status,
  output logic [15:0] residual,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [7:0]  bus_out,
  output logic        bus_out_parity,
  output logic        operational_out,
  output logic        hold_out,
  output logic        select_out,
  output logic        address_out,
  output logic        command_out,
  output logic        service_out,
  output logic        suppress_out,
  input  logic [7:0]  bus_in,
  input  logic        bus_in_parity,
  input  logic        operational_in,
  input  logic        request_in,
  input  logic        select_in,
  input  logic        address_in,
  input  logic        status_in,
  input  logic        service_in
);
  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_WAIT_ADDR, S_SHORT, S_COMMAND, S_INIT, S_INIT_DROP,
    S_DATA, S_END, S_END_DROP, S_ABORT
  } state_t;
  localparam logic [2:0] R_OK = 3'd0, R_SHORT = 3'd1, R_NODEV = 3'd2, R_TMO = 3'd3, R_PAR = 3'd4, R_ADDR = 3'd5;
  state_t state_q, state_d;
  logic [7:0] addr_q, addr_d, cmd_q, cmd_d, status_q, status_d, rx_data_q, rx_data_d, bus_out_q, bus_out_d;
  logic [15:0] timer_q, timer_d, residual_q, residual_d;
  logic [4:0] in_q, in_d;
  logic [2:0] result_q, result_d;
  logic busy_q, busy_d, done_q, done_d, tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic bus_out_parity_q, bus_out_parity_d, operational_out_q, operational_out_d;
  logic hold_out_q, hold_out_d, select_out_q, select_out_d, address_out_q, address_out_d;
  logic command_out_q, command_out_d, service_out_q, service_out_d;
  logic ctrl, is_read, par_bad, fin, wait_tx, unused_in;
  assign ctrl = ~^cmd_q[1:0];
  assign is_read = cmd_q[1:0] == 2'b10;
  assign in_d = {operational_in, address_in, status_in, select_in, service_in};
`ifdef CHANNEL_PARITY_CHECK_EN
  assign par_bad = ~^{bus_in, bus_in_parity};
  assign unused_in = request_in;
`else
  assign par_bad = 1'b0;
  assign unused_in = request_in ^ bus_in_parity;
`endif
  // sequencer: next state, registered outputs and timeout counter
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cmd_d = cmd_q;
    status_d = status_q;
    rx_data_d = rx_data_q;
    bus_out_d = bus_out_q;
    residual_d = residual_q;
    result_d = result_q;
    busy_d = busy_q;
    done_d = 1'b0;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    operational_out_d = 1'b1;
    hold_out_d = hold_out_q;
    select_out_d = select_out_q;
    address_out_d = address_out_q;
    command_out_d = command_out_q;
    service_out_d = service_out_q;
    fin = 1'b0;
    wait_tx = 1'b0;
    if (state_q != S_IDLE && state_q != S_ABORT && timer_q >= TIMEOUT) begin
      state_d = S_ABORT;
      result_d = R_TMO;
    end else begin
      case (state_q)
        S_IDLE: if (start && !done_q) begin
          addr_d = dev_address;
          cmd_d = dev_command;
          residual_d = byte_count;
          busy_d = 1'b1;
          state_d = S_SELECT;
        end
        S_SELECT: begin
          bus_out_d = addr_q;
          address_out_d = 1'b1;
          hold_out_d = 1'b1;
          select_out_d = 1'b1;
          state_d = S_WAIT_ADDR;
        end
        S_WAIT_ADDR:
          if (operational_in && address_in) begin
            state_d = S_ABORT;
            result_d = par_bad ? R_PAR : R_ADDR;
            if (!par_bad && bus_in == addr_q) begin
              address_out_d = 1'b0;
              state_d = S_COMMAND;
            end
          end else if (status_in && !operational_in) begin
            if (par_bad) begin
              state_d = S_ABORT;
              result_d = R_PAR;
            end else begin
              status_d = bus_in;
              select_out_d = 1'b0;
              hold_out_d = 1'b0;
              address_out_d = 1'b0;
              state_d = S_SHORT;
            end
          end else if (select_in) begin
            state_d = S_ABORT;
            result_d = R_NODEV;
          end
        S_SHORT: if (!status_in) begin
          fin = 1'b1;
          result_d = R_SHORT;
        end
        S_COMMAND:
          if (!command_out_q) begin
            if (!address_in) begin
              bus_out_d = cmd_q;
              command_out_d = 1'b1;
            end
          end else if (!address_in && operational_in) begin
            command_out_d = 1'b0;
            state_d = S_INIT;
          end
        S_INIT, S_END: if (status_in) begin
          if (par_bad) begin
            state_d = S_ABORT;
            result_d = R_PAR;
          end else begin
            status_d = bus_in;
            service_out_d = 1'b1;
            state_d = state_q == S_INIT ? S_INIT_DROP : S_END_DROP;
          end
        end
        S_INIT_DROP: if (!status_in) begin
          service_out_d = 1'b0;
          if (status_q[4] || (status_q[3] && status_q[2]) || ctrl) begin
            fin = 1'b1;
            result_d = R_OK;
          end else state_d = S_DATA;
        end
        S_END_DROP: if (!status_in) begin
          fin = 1'b1;
          result_d = R_OK;
        end
        S_DATA:
          if (service_out_q || command_out_q) begin
            if (!service_in) begin
              service_out_d = 1'b0;
              command_out_d = 1'b0;
            end
          end else if (status_in && operational_in) state_d = S_END;
          else if (service_in) begin
            if (par_bad) begin
              state_d = S_ABORT;
              result_d = R_PAR;
            end else if (residual_q == 16'd0) command_out_d = 1'b1;
            else if (is_read) begin
              rx_data_d = bus_in;
              rx_valid_d = 1'b1;
              residual_d = residual_q - 16'd1;
              service_out_d = 1'b1;
            end else if (tx_valid) begin
              bus_out_d = tx_data;
              tx_ready_d = 1'b1;
              residual_d = residual_q - 16'd1;
              service_out_d = 1'b1;
            end else wait_tx = 1'b1;
          end
        S_ABORT: fin = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
    if (fin) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = S_IDLE;
      hold_out_d = 1'b0;
      select_out_d = 1'b0;
      address_out_d = 1'b0;
      command_out_d = 1'b0;
      service_out_d = 1'b0;
    end
    bus_out_parity_d = ~^bus_out_d;
    timer_d = (state_d != state_q || in_d != in_q) ? 16'd0 : wait_tx ? timer_q : timer_q + 16'd1;
  end
  // state and output registers, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      cmd_q <= '0;
      status_q <= '0;
      rx_data_q <= '0;
      bus_out_q <= '0;
      residual_q <= '0;
      timer_q <= '0;
      in_q <= '0;
      result_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      bus_out_parity_q <= 1'b0;
      operational_out_q <= 1'b0;
      hold_out_q <= 1'b0;
      select_out_q <= 1'b0;
      address_out_q <= 1'b0;
      command_out_q <= 1'b0;
      service_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cmd_q <= cmd_d;
      status_q <= status_d;
      rx_data_q <= rx_data_d;
      bus_out_q <= bus_out_d;
      residual_q <= residual_d;
      timer_q <= timer_d;
      in_q <= in_d;
      result_q <= result_d;
      busy_q <= busy_d;
      done_q <= done_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      bus_out_parity_q <= bus_out_parity_d;
      operational_out_q <= operational_out_d;
      hold_out_q <= hold_out_d;
      select_out_q <= select_out_d;
      address_out_q <= address_out_d;
      command_out_q <= command_out_d;
      service_out_q <= service_out_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign result = result_q;
  assign status = status_q;
  assign residual = residual_q;
  assign tx_ready = tx_ready_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign bus_out = bus_out_q;
  assign bus_out_parity = bus_out_parity_q;
  assign operational_out = operational_out_q;
  assign hold_out = hold_out_q;
  assign select_out = select_out_q;
  assign address_out = address_out_q;
  assign command_out = command_out_q;
  assign service_out = service_out_q;
  assign suppress_out = 1'b0;
endmodule

// File: tb/tb_channel_selector.sv
// tb_channel_selector: randomized device/host bench for channel_selector against a transaction-level model
module tb_channel_selector;
  localparam int K_NORM = 0, K_NODEV = 1, K_SHORT = 2, K_MISM = 3;
  localparam int T_ADDR = 0, T_CMD = 1, T_SVC = 2, T_SEL = 3, T_DONE = 4, T_RESP = 5;
  logic clk = 1'b0, reset_n, start, busy, done, tx_valid, tx_ready, rx_valid, bus_out_parity;
  logic [7:0] dev_address, dev_command, status, tx_data, rx_data, bus_out, bus_in;
  logic [15:0] byte_count, residual;
  logic [2:0] result;
  logic operational_out, hold_out, select_out, address_out, command_out, service_out, suppress_out;
  logic bus_in_parity, operational_in, request_in, select_in, address_in, status_in, service_in;
  logic [7:0] tx_pool [256];
  logic [7:0] dev_bytes [8];
  logic [7:0] tx_idx = 8'd0;
  logic [7:0] exp_status = 8'd0;
  logic [7:0] rx_q [$];
  int errors = 0, checks = 0;

  channel_selector #(.TIMEOUT(16'd50)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dev_address(dev_address), .dev_command(dev_command),
    .byte_count(byte_count), .busy(busy), .done(done), .result(result), .status(status), .residual(residual),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_out(bus_out), .bus_out_parity(bus_out_parity), .operational_out(operational_out), .hold_out(hold_out),
    .select_out(select_out), .address_out(address_out), .command_out(command_out), .service_out(service_out),
    .suppress_out(suppress_out), .bus_in(bus_in), .bus_in_parity(bus_in_parity), .operational_in(operational_in),
    .request_in(request_in), .select_in(select_in), .address_in(address_in), .status_in(status_in),
    .service_in(service_in)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid) rx_q.push_back(rx_data);

  initial begin
    tx_valid = 1'b0;
    tx_data = 8'd0;
    forever begin
      @(negedge clk);
      if (tx_ready) tx_idx = tx_idx + 8'd1;
      tx_data = tx_pool[tx_idx];
      tx_valid = $urandom_range(0, 9) < 7;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic tag_val(input int t);
    case (t)
      T_ADDR: return address_out;
      T_CMD: return command_out;
      T_SVC: return service_out;
      T_SEL: return select_out;
      T_DONE: return done;
      default: return service_out | command_out;
    endcase
  endfunction

  task automatic wait_out(input int t, input logic v, input string tag);
    for (int i = 0; i < 300 && tag_val(t) !== v; i++) @(negedge clk);
    check(tag, 32'(tag_val(t)), 32'(v));
  endtask

  task automatic put_bus(input logic [7:0] b);
    bus_in = b;
    bus_in_parity = ~^b;
  endtask

  task automatic clear_dev();
    operational_in = 1'b0;
    select_in = 1'b0;
    address_in = 1'b0;
    status_in = 1'b0;
    service_in = 1'b0;
    put_bus(8'd0);
  endtask

  task automatic issue(input logic [7:0] adr, input logic [7:0] cmd, input logic [15:0] cnt);
    @(negedge clk);
    dev_address = adr;
    dev_command = cmd;
    byte_count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_txn(input int kind, input logic [7:0] adr, input logic [7:0] cmd, input logic [15:0] cnt,
                         input int nreq, input logic [7:0] ist, input logic [7:0] est);
    logic [7:0] txg [$];
    logic stop_seen = 1'b0;
    logic rd = cmd[1:0] == 2'b10;
    logic init_end = ist[4] || (ist[3] && ist[2]) || cmd[1:0] == 2'b00 || cmd[1:0] == 2'b11;
    logic do_data = kind == K_NORM && !init_end;
    int xfer = do_data ? (nreq < int'(cnt) ? nreq : int'(cnt)) : 0;
    logic [2:0] e_res = kind == K_NODEV ? 3'd2 : kind == K_SHORT ? 3'd1 : kind == K_MISM ? 3'd5 : 3'd0;
    logic [7:0] tx_start = tx_idx;
    if (kind == K_SHORT) exp_status = ist;
    else if (kind == K_NORM) exp_status = do_data ? est : ist;
    rx_q.delete();
    issue(adr, cmd, cnt);
    wait_out(T_ADDR, 1'b1, "addr_out_rise");
    if (kind == K_NODEV) select_in = 1'b1;
    else if (kind == K_SHORT) begin
      put_bus(ist);
      status_in = 1'b1;
      wait_out(T_SEL, 1'b0, "short_sel_drop");
      status_in = 1'b0;
    end else begin
      put_bus(kind == K_MISM ? adr ^ 8'h81 : adr);
      operational_in = 1'b1;
      address_in = 1'b1;
      if (kind == K_NORM) begin
        wait_out(T_ADDR, 1'b0, "addr_out_drop");
        address_in = 1'b0;
        wait_out(T_CMD, 1'b1, "cmd_out_rise");
        check("cmd_byte", 32'(bus_out), 32'(cmd));
        check("cmd_parity", 32'(^{bus_out, bus_out_parity}), 32'd1);
        wait_out(T_CMD, 1'b0, "cmd_out_drop");
        put_bus(ist);
        status_in = 1'b1;
        wait_out(T_SVC, 1'b1, "init_svc_rise");
        status_in = 1'b0;
        wait_out(T_SVC, 1'b0, "init_svc_drop");
        if (do_data) begin
          for (int i = 0; i < nreq; i++) begin
            put_bus(dev_bytes[i]);
            service_in = 1'b1;
            wait_out(T_RESP, 1'b1, "data_resp_rise");
            if (command_out) stop_seen = 1'b1;
            else if (!rd) txg.push_back(bus_out);
            service_in = 1'b0;
            wait_out(T_RESP, 1'b0, "data_resp_drop");
            if (stop_seen) break;
          end
          put_bus(est);
          status_in = 1'b1;
          wait_out(T_SVC, 1'b1, "end_svc_rise");
          status_in = 1'b0;
        end
      end
    end
    wait_out(T_DONE, 1'b1, "done_pulse");
    check("result", 32'(result), 32'(e_res));
    check("status", 32'(status), 32'(exp_status));
    check("residual", 32'(residual), 32'(cnt) - 32'(xfer));
    check("busy_end", 32'(busy), 32'd0);
    check("tags_end", 32'({operational_out, hold_out, select_out, address_out, command_out, service_out}), 32'h20);
    check("stop", 32'(stop_seen), 32'(do_data && nreq > int'(cnt)));
    check("rx_count", 32'(rx_q.size()), 32'(rd ? xfer : 0));
    check("tx_count", 32'(8'(tx_idx - tx_start)), 32'(rd ? 0 : xfer));
    for (int i = 0; i < rx_q.size() && i < xfer; i++) check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(dev_bytes[i]));
    for (int i = 0; i < txg.size() && i < xfer; i++) check($sformatf("tx_byte%0d", i), 32'(txg[i]), 32'(tx_pool[8'(tx_start + 8'(i))]));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_ignored", 32'({busy, done}), 32'd0);
    clear_dev();
  endtask

  initial begin
    logic seen;
    int n;
    for (int i = 0; i < 256; i++) tx_pool[i] = 8'($urandom);
    reset_n = 1'b0;
    start = 1'b0;
    dev_address = 8'd0;
    dev_command = 8'd0;
    byte_count = 16'd0;
    request_in = 1'b0;
    clear_dev();
    repeat (3) @(negedge clk);
    check("rst_data", {status, residual, rx_data}, 32'd0);
    check("rst_ctl", 32'({busy, done, result, tx_ready, rx_valid, bus_out, bus_out_parity, operational_out,
                          hold_out, select_out, address_out, command_out, service_out, suppress_out}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("op_out_up", 32'(operational_out), 32'd1);
    run_txn(K_NORM, 8'hFF, 8'h03, 16'd0, 0, 8'h0C, 8'h00);
    dev_bytes[0] = 8'h01;
    dev_bytes[1] = 8'h02;
    dev_bytes[2] = 8'h03;
    run_txn(K_NORM, 8'h10, 8'h02, 16'd3, 3, 8'h00, 8'h0C);
    run_txn(K_NORM, 8'h20, 8'h01, 16'd2, 4, 8'h00, 8'h0C);
    run_txn(K_NORM, 8'h24, 8'h02, 16'd0, 2, 8'h00, 8'h0C);
    run_txn(K_SHORT, 8'h30, 8'h02, 16'd4, 0, 8'h10, 8'h00);
    run_txn(K_NODEV, 8'h42, 8'h02, 16'd4, 0, 8'h00, 8'h00);
    run_txn(K_MISM, 8'h43, 8'h01, 16'd1, 0, 8'h00, 8'h00);
    issue(8'h11, 8'h03, 16'd0);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency_ok", 32'(n >= 50 && n <= 54), 32'd1);
    check("timeout_result", 32'(result), 32'd3);
    check("timeout_tags", 32'({hold_out, select_out, address_out, command_out, service_out}), 32'd0);
    @(negedge clk);
`ifdef CHANNEL_PARITY_CHECK_EN
    issue(8'h21, 8'h02, 16'd2);
    wait_out(T_ADDR, 1'b1, "par_addr_rise");
    put_bus(8'h21);
    operational_in = 1'b1;
    address_in = 1'b1;
    wait_out(T_ADDR, 1'b0, "par_addr_drop");
    address_in = 1'b0;
    wait_out(T_CMD, 1'b1, "par_cmd_rise");
    wait_out(T_CMD, 1'b0, "par_cmd_drop");
    bus_in = 8'h0C;
    bus_in_parity = 1'b0;
    status_in = 1'b1;
    wait_out(T_DONE, 1'b1, "par_done");
    check("par_result", 32'(result), 32'd4);
    check("par_status", 32'(status), 32'(exp_status));
    check("par_tags", 32'({operational_out, hold_out, select_out, address_out, command_out, service_out}), 32'h20);
    clear_dev();
    @(negedge clk);
`endif
    for (int t = 0; t < 30; t++) begin
      int r = $urandom_range(0, 9);
      int k = r == 0 ? K_NODEV : r == 1 ? K_SHORT : r == 2 ? K_MISM : K_NORM;
      int c = $urandom_range(0, 5);
      logic [7:0] cmd = {6'($urandom), c == 0 ? 2'b00 : c == 1 ? 2'b11 : c < 4 ? 2'b01 : 2'b10};
      int s = $urandom_range(0, 5);
      logic [7:0] ist = s == 0 ? 8'h0C : s == 1 ? 8'($urandom) | 8'h10 : 8'($urandom) & 8'hE3;
      for (int i = 0; i < 8; i++) dev_bytes[i] = 8'($urandom);
      run_txn(k, 8'($urandom), cmd, 16'($urandom_range(0, 5)), $urandom_range(0, 7),
              k == K_SHORT ? 8'($urandom) : ist, 8'($urandom));
    end
    issue(8'h55, 8'h02, 16'd4);
    wait_out(T_ADDR, 1'b1, "midrst_addr_rise");
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_tags", 32'({operational_out, hold_out, select_out, address_out, command_out, service_out, busy, done}), 32'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= done;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    check("midrst_idle", 32'({operational_out, busy, address_out}), 32'h4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/channel_selector.md
# channel_selector

Channel-side sequencer for one parallel (bus-and-tag) channel interface. Accepts a single I/O request from the host logic, performs initial selection of the addressed control unit, issues the command, and accepts initial status. It then runs the byte-by-byte service-in/service-out data transfer or issues a stop, and accepts ending status. It sits between host logic and the channel "A"-side tag and bus pins, and is the sole driver of outbound tags.

## Interface
Parameters:
- `TIMEOUT`, 16'd1000: cycles to wait for any expected inbound tag transition before aborting.

Ports:
- `clk` input 1: clock. One clock; all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle request pulse; ignored while `busy`.
- `dev_address` input 8: device address, sampled on `start`.
- `dev_command` input 8: command byte, sampled on `start`.
- `byte_count` input 16: bytes to transfer, sampled on `start`.
- `busy` output 1: request in progress.
- `done` output 1: one-cycle pulse at completion.
- `result` output 3: valid with `done`.
  - 0 OK; 1 SHORT_BUSY; 2 NO_DEVICE; 3 TIMEOUT; 4 PARITY; 5 ADDR_MISMATCH.
- `status` output 8: last status byte accepted.
- `residual` output 16: bytes not transferred.
- `tx_data` input 8, `tx_valid` input 1, `tx_ready` output 1: write source. `tx_ready` pulses when a byte is consumed.
- `rx_data` output 8, `rx_valid` output 1: read sink, one-cycle pulse, no backpressure.
- `bus_out` output 8, `bus_out_parity` output 1: channel data out. Parity is odd parity of `bus_out`.
- `operational_out`, `hold_out`, `select_out`, `address_out`, `command_out`, `service_out`, `suppress_out` output 1 each: outbound tags.
- `bus_in` input 8, `bus_in_parity` input 1: channel data in.
- `operational_in`, `request_in`, `select_in`, `address_in`, `status_in`, `service_in` input 1 each: inbound tags.

## Operation
- All outputs are registered. In reset every output is 0 and `status`/`residual` are cleared.
- `operational_out` rises on the first cycle after `reset_n` goes high. `suppress_out` is tied to 0. `request_in` is ignored.
- Direction is taken from the command: `dev_command[1:0]`==01 is WRITE, ==10 is READ. Any other value is control; control commands have no data phase.

States:
- IDLE: waits for `start`. Latches inputs and loads `residual` from `byte_count`.
- SELECT: drives `bus_out`=address and asserts `address_out`, `hold_out` and `select_out` together, then moves to WAIT_ADDR_IN.
- WAIT_ADDR_IN: the first of the following conditions wins:
  - `operational_in`&&`address_in`: compare `bus_in` with the address. On a match, drop `address_out` and go to COMMAND. On a mismatch, go to ABORT with ADDR_MISMATCH.
  - `status_in`&&!`operational_in`: latch `status`, drop `select_out`/`hold_out`/`address_out`, wait for `status_in`=0, then finish with SHORT_BUSY.
  - `select_in`: go to ABORT with NO_DEVICE.
- COMMAND: once `address_in`=0, drive `bus_out`=command and assert `command_out`. Hold it until `address_in` has fallen and `operational_in` is high, then drop `command_out`.
- INIT_STATUS: on `status_in`, latch `bus_in` into `status` and assert `service_out`. Drop `service_out` after `status_in` falls.
  - Finish with OK if `status[4]` (BUSY) is set, if `status[3]&&status[2]` (CE+DE) are set, or if the command is a control command.
  - Otherwise go to DATA.
- DATA: on each `service_in` rising edge:
  - READ with `residual`>0: present `bus_in` on `rx_data`, pulse `rx_valid`, decrement `residual`, assert `service_out`.
  - WRITE with `residual`>0 and `tx_valid`: drive `bus_out`=`tx_data`, pulse `tx_ready`, decrement `residual`, assert `service_out`. If `tx_valid`=0, wait with no tag raised.
  - `residual`==0: assert `command_out` (stop) instead of `service_out`.
  - The raised tag drops after `service_in` falls.
  - `status_in` (with `operational_in`) moves to END_STATUS.
- END_STATUS: accept status as in INIT_STATUS, drop `select_out`/`hold_out`, finish with OK.
- ABORT: drop all outbound tags except `operational_out` in one cycle, then finish.
- Finish: pulse `done` with `result` for one cycle, clear `busy`, return to IDLE.

## Timing
- `start` to `address_out` high is 2 cycles.
- Each outbound response tag rises 1 cycle after the inbound edge is sampled. It falls 1 cycle after the inbound tag is sampled low.
- `tx_ready` and `rx_valid` coincide with the cycle `service_out` rises.
- Timeout:
  - A counter is cleared on every state change and on every inbound tag edge.
  - When it reaches `TIMEOUT` in any non-IDLE state, go to ABORT with TIMEOUT.
  - While DATA is waiting on `tx_valid`, the counter is frozen.
- `residual` never underflows. With `byte_count`=0 and a data command, the first `service_in` is answered with stop.
- `start` asserted together with `done` is ignored.
- `reset_n` low mid-operation: all tags are 0 at the next edge and no `done` is produced.

## Configuration
- `CHANNEL_PARITY_CHECK_EN` defined: `bus_in` odd parity is checked on the cycle each of `address_in`, `status_in` or `service_in` is sampled high. A mismatch goes to ABORT with PARITY; the byte is not accepted, and `rx_valid`/`status` are unchanged.
- Undefined: `bus_in_parity` is ignored.

## Test plan
- NOP 0x03 to address 0xFF, device answers CE+DE (0x0C) -> `done`, `result`=0, `status`=0x0C, no `service_in` phase.
- READ 0x02, `byte_count`=3, device sends 0x01,0x02,0x03 then status 0x0C -> three `rx_valid` pulses with those bytes, `residual`=0, `result`=0.
- WRITE 0x01, `byte_count`=2, device requests 4 bytes -> two `tx_ready` pulses, then `command_out` stop on the third `service_in`, ending status 0x0C, `residual`=0.
- Device answers `status_in` without `operational_in`, with 0x10 -> `select_out` drops, `result`=1, `status`=0x10.
- No device at 0x42 (`select_in` returns) -> `result`=2. Separately, tags never answer with `TIMEOUT`=50 -> `result`=3 within 52 cycles of the last edge.
- With `CHANNEL_PARITY_CHECK_EN`, status byte 0x0C sent with even parity -> `result`=4, `status` unchanged, all tags except `operational_out` low.
